// File: rtl/alu_serial_pkg.sv
// Shared types and op-code constants for the bit-serial ALU sequencer.
package alu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUM = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; cout is always the full-adder carry.
module alu_bit_slice
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] operacion,
    output logic       res,
    output logic       cout
);

    always_comb begin
        res  = 1'b0;
        cout = (a & b) | (cin & (a ^ b));
        case (operacion)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SUM:  res = a ^ b ^ cin;
            OP_XOR:  res = a ^ b;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving one alu_bit_slice LSB-first.
// Optional zero/overflow flag ports are enabled by defining ALU_SERIAL_FLAGS_EN.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   RUN   | one result bit per cycle, carry held in carry_q
//   DONE  | first cycle settles flags, then holds result with out_valid=1
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [1:0]   operacion,
    input  logic         Ainv,
    input  logic         Binv,
    input  logic         Cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] resultado,
    output logic         Cout
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic         zero,
    output logic         overflow
`endif
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]    op_q, op_d;
    logic          ainv_q, ainv_d, binv_q, binv_d;
    logic          cout_q, cout_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
`ifdef ALU_SERIAL_FLAGS_EN
    logic          zero_q, zero_d, ovf_q, ovf_d;
`endif

    logic sl_a, sl_b, sl_res, sl_cout;

    assign sl_a = a_q[cnt_q] ^ ainv_q;
    assign sl_b = b_q[cnt_q] ^ binv_q;

    alu_bit_slice u_slice (
        .a         (sl_a),
        .b         (sl_b),
        .cin       (carry_q),
        .operacion (op_q),
        .res       (sl_res),
        .cout      (sl_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        op_d        = op_q;
        ainv_d      = ainv_q;
        binv_d      = binv_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef ALU_SERIAL_FLAGS_EN
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    op_d       = operacion;
                    ainv_d     = Ainv;
                    binv_d     = Binv;
                    carry_d    = Cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                res_d[cnt_q] = sl_res;
                carry_d      = sl_cout;
                if (cnt_q == LAST) begin
                    cout_d  = sl_cout;
`ifdef ALU_SERIAL_FLAGS_EN
                    ovf_d   = carry_q ^ sl_cout;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle lets the assembled word settle before it is presented.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
                    zero_d      = (res_q == '0);
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            op_q        <= 2'b00;
            ainv_q      <= 1'b0;
            binv_q      <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            op_q        <= op_d;
            ainv_q      <= ainv_d;
            binv_q      <= binv_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign resultado = res_q;
    assign Cout      = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zero      = zero_q;
    assign overflow  = ovf_q;
`endif

endmodule
